// File: rtl/host_mem_loader_pkg.sv
// Shared definitions for the host-side memory loader and the blocks it talks to.
package host_mem_loader_pkg;

  localparam int unsigned ADDR_W_DFLT = 8;
  localparam int unsigned DATA_W_DFLT = 8;

  typedef enum logic [2:0] {
    IM_LEN,
    IM_DATA,
    DM_LEN,
    DM_DATA,
    RUN,
    DUMP_RD,
    DUMP_TX,
    DONE
  } loader_state_e;

  function automatic logic is_load_state(input loader_state_e s);
    return s inside {IM_LEN, IM_DATA, DM_LEN, DM_DATA};
  endfunction

endpackage

// File: rtl/mem_dump_streamer.sv
// Reads a fixed DMEM window one word at a time and hands each word to the host link.
module mem_dump_streamer #(
  parameter int unsigned              ADDR_W    = 8,
  parameter int unsigned              DATA_W    = 8,
  parameter logic [ADDR_W-1:0]        DUMP_BASE = '0,
  parameter int unsigned              DUMP_LEN  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  output logic              finish
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DUMP_LEN - 1);

  logic              rd_q;
  logic              first_q;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] hold_q;
  logic              accept;
  logic              last;

  assign accept   = tx_valid && tx_ready;
  assign last     = (idx == LAST_IDX);
  assign finish   = accept && last;
  assign rd_addr  = DUMP_BASE + idx;
  // Synchronous DMEM returns data in the first TX cycle; it is held from then on.
  assign tx_data  = first_q ? dm_rdata : hold_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q     <= 1'b0;
      first_q  <= 1'b0;
      tx_valid <= 1'b0;
      idx      <= '0;
      hold_q   <= '0;
    end else begin
      first_q <= 1'b0;
      if (first_q) hold_q <= dm_rdata;
      if (start) begin
        rd_q <= 1'b1;
        idx  <= '0;
      end else if (rd_q) begin
        rd_q     <= 1'b0;
        tx_valid <= 1'b1;
        first_q  <= 1'b1;
      end else if (accept) begin
        tx_valid <= 1'b0;
        if (!last) begin
          idx  <= idx + ADDR_W'(1);
          rd_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/host_mem_loader.sv
// Loads IMEM/DMEM from the host byte stream, runs the core, then dumps a DMEM window back.
module host_mem_loader
  import host_mem_loader_pkg::*;
#(
  parameter int unsigned       ADDR_W    = ADDR_W_DFLT,
  parameter int unsigned       DATA_W    = DATA_W_DFLT,
  parameter logic [ADDR_W-1:0] DUMP_BASE = '0,
  parameter int unsigned       DUMP_LEN  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] im_addr,
  output logic [DATA_W-1:0] im_wdata,
  output logic              im_wr,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  output logic              dm_wr,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              core_rst_n,
  input  logic              end_op,
  output logic              busy,
  output logic              done
);

  loader_state_e     state, state_nxt;
  logic [DATA_W-1:0] cnt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] dm_addr_q;
  logic [ADDR_W-1:0] rd_addr;
  logic              rx_acc;
  logic              dump_start;
  logic              dump_finish;
  logic              last_byte;

  assign rx_acc     = rx_valid && rx_ready;
  assign last_byte  = (cnt == DATA_W'(1));
  assign dump_start = (state == RUN) && end_op;
  assign busy       = (state != IM_LEN);
  assign done       = (state == DONE);
  assign dm_addr    = (state == DUMP_RD || state == DUMP_TX) ? rd_addr : dm_addr_q;

  always_comb begin
    state_nxt = state;
    case (state)
      IM_LEN:  if (rx_acc) state_nxt = (rx_data == '0) ? DM_LEN : IM_DATA;
      IM_DATA: if (rx_acc && last_byte) state_nxt = DM_LEN;
      DM_LEN:  if (rx_acc) state_nxt = (rx_data == '0) ? RUN : DM_DATA;
      DM_DATA: if (rx_acc && last_byte) state_nxt = RUN;
      RUN:     if (end_op) state_nxt = DUMP_RD;
      DUMP_RD: state_nxt = DUMP_TX;
      DUMP_TX: if (tx_valid && tx_ready) state_nxt = dump_finish ? DONE : DUMP_RD;
      DONE:    state_nxt = IM_LEN;
      default: state_nxt = IM_LEN;
    endcase
  end

  // rx_ready and core_rst_n are registered from the next state so they track it cycle-exactly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IM_LEN;
      cnt        <= '0;
      addr       <= '0;
      rx_ready   <= 1'b0;
      im_wr      <= 1'b0;
      im_addr    <= '0;
      im_wdata   <= '0;
      dm_wr      <= 1'b0;
      dm_addr_q  <= '0;
      dm_wdata   <= '0;
      core_rst_n <= 1'b0;
    end else begin
      state      <= state_nxt;
      rx_ready   <= is_load_state(state_nxt);
      core_rst_n <= (state_nxt == RUN);
      im_wr      <= 1'b0;
      dm_wr      <= 1'b0;
      if (rx_acc) begin
        case (state)
          IM_LEN, DM_LEN: begin
            cnt  <= rx_data;
            addr <= '0;
          end
          IM_DATA: begin
            im_wr    <= 1'b1;
            im_addr  <= addr;
            im_wdata <= rx_data;
            addr     <= addr + ADDR_W'(1);
            cnt      <= cnt - DATA_W'(1);
          end
          DM_DATA: begin
            dm_wr     <= 1'b1;
            dm_addr_q <= addr;
            dm_wdata  <= rx_data;
            addr      <= addr + ADDR_W'(1);
            cnt       <= cnt - DATA_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

  mem_dump_streamer #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .DUMP_BASE (DUMP_BASE),
    .DUMP_LEN  (DUMP_LEN)
  ) u_dump (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (dump_start),
    .tx_ready (tx_ready),
    .dm_rdata (dm_rdata),
    .rd_addr  (rd_addr),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .finish   (dump_finish)
  );

endmodule
